bnn_sample_streamer: RTL and testbench

Parametrised stimulus-and-scoreboard block for the BNN pipeline. Holds a loadable bank of NSAMPLES input vectors and one-hot target vectors, streams the inputs into the BNN datapath one per cycle, and delays each target through a DEPTH-stage valid-tagged delay line so that it lines up with the network output. It compares the BNN result against each aligned target and accumulates correct and total counts. It supports pause (bubble insertion), continuous looping over the sample bank, and run-time loading.

---
 rtl/bnn_sample_streamer.sv | 141 ++++++++++++++
 tb/tb_bnn_sample_streamer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bnn_sample_streamer.sv
// Sample bank, issue sequencer and target delay line that feeds a BNN datapath
// and scores its outputs against one-hot targets aligned to the network latency.
module bnn_sample_streamer #(
    parameter int unsigned IWIDTH   = 784,
    parameter int unsigned OWIDTH   = 10,
    parameter int unsigned NSAMPLES = 10,
    parameter int unsigned CWIDTH   = 4,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned CNTW     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_en,
    input  logic              ld_tgt,
    input  logic [CWIDTH-1:0] ld_addr,
    input  logic [IWIDTH-1:0] ld_data,
    input  logic              start,
    input  logic              pause,
    input  logic              loop,
    input  logic [OWIDTH-1:0] vecY,
    output logic [IWIDTH-1:0] vecX,
    output logic              x_valid,
    output logic [OWIDTH-1:0] vecT,
    output logic              t_valid,
    output logic              match,
    output logic              busy,
    output logic              done,
    output logic [CNTW-1:0]   n_correct,
    output logic [CNTW-1:0]   n_total
);

    localparam int unsigned NSLOTS = 2 ** CWIDTH;
    localparam logic [CWIDTH-1:0] LAST_IDX = CWIDTH'(NSAMPLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [CWIDTH-1:0] idx_q, idx_d;
    logic              busy_d, done_d, issue, clr;
    logic              ld_ok;

    logic [IWIDTH-1:0] x_bank [NSLOTS];
    logic [OWIDTH-1:0] t_bank [NSLOTS];

    // Valid-tagged target delay line; t_valid/vecT form the output stage.
    logic [DEPTH-1:0]  vld_q;
    logic [OWIDTH-1:0] tgt_q [DEPTH];

    assign match = t_valid && (vecY == vecT);
    assign ld_ok = ld_en && (state_q == IDLE) && !busy && (32'(ld_addr) < NSAMPLES);

    // Bank survives reset so a run can be restarted without reloading.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            if (ld_tgt) t_bank[ld_addr] <= ld_data[OWIDTH-1:0];
            else        x_bank[ld_addr] <= ld_data;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy;
        done_d  = 1'b0;
        issue   = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                    clr     = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ISSUE: begin
                if (!pause) begin
                    issue = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        if (loop) idx_d = '0;
                        else      state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + CWIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                // Last live target is at the output and nothing remains behind it.
                if (t_valid && !(|vld_q)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            x_valid   <= 1'b0;
            vecX      <= '0;
            vld_q     <= '0;
            for (int i = 0; i < DEPTH; i++) tgt_q[i] <= '0;
            t_valid   <= 1'b0;
            vecT      <= '0;
            n_correct <= '0;
            n_total   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy    <= busy_d;
            done    <= done_d;
            x_valid <= issue;
            if (issue) vecX <= x_bank[idx_q];

            vld_q[0] <= issue;
            tgt_q[0] <= issue ? t_bank[idx_q] : '0;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                tgt_q[i] <= tgt_q[i-1];
            end
            t_valid <= vld_q[DEPTH-1];
            vecT    <= tgt_q[DEPTH-1];

            // Saturating scoreboard counters.
            if (clr) begin
                n_correct <= '0;
                n_total   <= '0;
            end else if (t_valid) begin
                if (n_total != '1) n_total <= n_total + CNTW'(1);
                if (match && (n_correct != '1)) n_correct <= n_correct + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bnn_sample_streamer.sv
// Directed bench for bnn_sample_streamer: small bank of 4 samples, 2-cycle latency,
// BNN output looped back from the aligned target (or forced to zero).
module tb_bnn_sample_streamer;

    localparam int unsigned IWIDTH   = 16;
    localparam int unsigned OWIDTH   = 4;
    localparam int unsigned NSAMPLES = 4;
    localparam int unsigned CWIDTH   = 3;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned CNTW     = 16;

    logic              clk, rst;
    logic              ld_en, ld_tgt, start, pause, loop;
    logic [CWIDTH-1:0] ld_addr;
    logic [IWIDTH-1:0] ld_data;
    logic [OWIDTH-1:0] vecY;
    logic [IWIDTH-1:0] vecX;
    logic              x_valid, t_valid, match, busy, done;
    logic [OWIDTH-1:0] vecT;
    logic [CNTW-1:0]   n_correct, n_total;
    logic              y_zero;

    int errors = 0;
    int checks = 0;

    logic [15:0] pvx [9];
    logic        pxv [9];
    logic        ptv [9];
    logic [3:0]  pvt [9];

    assign vecY = y_zero ? '0 : vecT;

    bnn_sample_streamer #(
        .IWIDTH(IWIDTH), .OWIDTH(OWIDTH), .NSAMPLES(NSAMPLES),
        .CWIDTH(CWIDTH), .DEPTH(DEPTH), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_tgt(ld_tgt), .ld_addr(ld_addr),
        .ld_data(ld_data), .start(start), .pause(pause), .loop(loop), .vecY(vecY),
        .vecX(vecX), .x_valid(x_valid), .vecT(vecT), .t_valid(t_valid), .match(match),
        .busy(busy), .done(done), .n_correct(n_correct), .n_total(n_total)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Basic 4-sample run; poke exercises start-during-ISSUE and a load while busy.
    task automatic run_basic(input string nm, input logic yz, input logic poke);
        logic              tv;
        logic [15:0]       vx;
        logic [3:0]        vt;
        y_zero = yz;
        start  = 1'b1;
        step();
        start = 1'b0;
        chk({nm, " busy@k"}, 32'(busy), 32'd1);
        chk({nm, " x_valid@k"}, 32'(x_valid), 32'd0);
        for (int j = 1; j <= 8; j++) begin
            step();
            vx = (j <= 4) ? 16'(16'h1111 * j) : 16'h4444;
            tv = (j >= 3) && (j <= 6);
            vt = tv ? 4'(1 << (j - 3)) : 4'h0;
            chk($sformatf("%s x_valid j%0d", nm, j), 32'(x_valid), 32'((j <= 4) ? 1 : 0));
            chk($sformatf("%s vecX j%0d", nm, j), 32'(vecX), 32'(vx));
            chk($sformatf("%s t_valid j%0d", nm, j), 32'(t_valid), 32'(tv));
            chk($sformatf("%s vecT j%0d", nm, j), 32'(vecT), 32'(vt));
            chk($sformatf("%s match j%0d", nm, j), 32'(match), 32'(tv && !yz));
            chk($sformatf("%s done j%0d", nm, j), 32'(done), 32'((j == 7) ? 1 : 0));
            chk($sformatf("%s busy j%0d", nm, j), 32'(busy), 32'((j < 7) ? 1 : 0));
            if (j == 7) begin
                chk({nm, " n_total"}, 32'(n_total), 32'd4);
                chk({nm, " n_correct"}, 32'(n_correct), yz ? 32'd0 : 32'd4);
            end
            if (poke && j == 1) begin
                start   = 1'b1;
                ld_en   = 1'b1;
                ld_tgt  = 1'b0;
                ld_addr = 3'd2;
                ld_data = 16'hBEEF;
            end
            if (poke && j == 2) begin
                start = 1'b0;
                ld_en = 1'b0;
            end
        end
        y_zero = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ld_en = 1'b0; ld_tgt = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; pause = 1'b0; loop = 1'b0; y_zero = 1'b0;
        pvx = '{16'h1111, 16'h1111, 16'h1111, 16'h2222, 16'h3333,
                16'h4444, 16'h4444, 16'h4444, 16'h4444};
        pxv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ptv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        pvt = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h2, 4'h4, 4'h8, 4'h0};

        step();
        step();
        chk("rst x_valid", 32'(x_valid), 32'd0);
        chk("rst vecX", 32'(vecX), 32'd0);
        chk("rst t_valid", 32'(t_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst n_total", 32'(n_total), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            ld_en = 1'b1; ld_tgt = 1'b0; ld_addr = 3'(i); ld_data = 16'(16'h1111 * (i + 1));
            step();
            ld_tgt = 1'b1; ld_data = 16'(1 << i);
            step();
        end
        ld_en = 1'b0;

        run_basic("s1", 1'b0, 1'b0);
        run_basic("s2", 1'b1, 1'b0);

        // Two pause bubbles after the first sample.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            step();
            chk($sformatf("p x_valid j%0d", j), 32'(x_valid), 32'(pxv[j-1]));
            chk($sformatf("p vecX j%0d", j), 32'(vecX), 32'(pvx[j-1]));
            chk($sformatf("p t_valid j%0d", j), 32'(t_valid), 32'(ptv[j-1]));
            chk($sformatf("p vecT j%0d", j), 32'(vecT), 32'(pvt[j-1]));
            chk($sformatf("p done j%0d", j), 32'(done), 32'((j == 9) ? 1 : 0));
            if (j == 1) pause = 1'b1;
            if (j == 3) pause = 1'b0;
        end
        chk("p n_total", 32'(n_total), 32'd4);
        chk("p n_correct", 32'(n_correct), 32'd4);

        // One wrapped pass, then drain.
        loop  = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            step();
            if (j <= 8) begin
                chk($sformatf("l x_valid j%0d", j), 32'(x_valid), 32'd1);
                chk($sformatf("l vecX j%0d", j), 32'(vecX), 32'(16'(16'h1111 * ((j - 1) % 4 + 1))));
            end else begin
                chk($sformatf("l x_valid j%0d", j), 32'(x_valid), 32'd0);
            end
            chk($sformatf("l done j%0d", j), 32'(done), 32'((j == 11) ? 1 : 0));
            if (j == 4) loop = 1'b0;
        end
        chk("l n_total", 32'(n_total), 32'd8);
        chk("l n_correct", 32'(n_correct), 32'd8);
        chk("l busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of ISSUE.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("r pre vecX", 32'(vecX), 32'h2222);
        #2 rst = 1'b1;
        #1;
        chk("r x_valid", 32'(x_valid), 32'd0);
        chk("r vecX", 32'(vecX), 32'd0);
        chk("r t_valid", 32'(t_valid), 32'd0);
        chk("r vecT", 32'(vecT), 32'd0);
        chk("r busy", 32'(busy), 32'd0);
        chk("r done", 32'(done), 32'd0);
        chk("r n_correct", 32'(n_correct), 32'd0);
        chk("r n_total", 32'(n_total), 32'd0);
        step();
        rst = 1'b0;
        run_basic("s5", 1'b0, 1'b0);

        // Out-of-range load in IDLE, then start/load pokes while busy.
        ld_en = 1'b1; ld_tgt = 1'b0; ld_addr = 3'd5; ld_data = 16'hDEAD;
        step();
        ld_en = 1'b0;
        run_basic("s6", 1'b0, 1'b1);
        step();
        chk("s6 idle x_valid", 32'(x_valid), 32'd0);
        chk("s6 idle busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
